// File: rtl/dcache_line_mover.sv
// -----------------------------------------------------------------------------
// dcache_line_mover
// Moves whole cache lines between the data-cache line RAM (port B) and main
// data memory (port B). On a miss it optionally writes back a dirty victim
// line, then refills the slot with the missing line. Both RAMs are byte-write
// BRAMs with a registered 1-cycle read, so each phase overlaps a read stream
// on one port with a write stream (one cycle behind) on the other port.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_wb                    victim dirty: write back before refilling
//   req_set                   cache set (line slot) index
//   req_victim_addr           memory word address of the victim line
//   req_miss_addr             memory word address of the missing line
//   busy                      transfer in progress (acceptance .. return to IDLE)
//   done                      one-cycle pulse when the refill has completed
//   c_en/c_we/c_addr/c_din    cache RAM port B controls and write data
//   c_dout                    cache RAM port B read data
//   m_en/m_we/m_addr/m_din    memory port B controls and write data
//   m_dout                    memory port B read data
// -----------------------------------------------------------------------------
module dcache_line_mover #(
  parameter int unsigned LINE_WORDS       = 4,   // power of 2, >= 2
  parameter int unsigned CACHE_ADDR_WIDTH = 8,
  parameter int unsigned MEM_ADDR_WIDTH   = 11,
  parameter int unsigned NUM_COL          = 4,
  parameter int unsigned COL_WIDTH        = 8,
  localparam int unsigned DATA_WIDTH      = NUM_COL * COL_WIDTH,
  localparam int unsigned OFS             = $clog2(LINE_WORDS),
  localparam int unsigned SET_WIDTH       = CACHE_ADDR_WIDTH - OFS
) (
  input  logic                        clk,
  input  logic                        nrst,

  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wb,
  input  logic [SET_WIDTH-1:0]        req_set,
  input  logic [MEM_ADDR_WIDTH-1:0]   req_victim_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]   req_miss_addr,
  output logic                        busy,
  output logic                        done,

  output logic                        c_en,
  output logic [NUM_COL-1:0]          c_we,
  output logic [CACHE_ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0]       c_din,
  input  logic [DATA_WIDTH-1:0]       c_dout,

  output logic                        m_en,
  output logic [NUM_COL-1:0]          m_we,
  output logic [MEM_ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]       m_din,
  input  logic [DATA_WIDTH-1:0]       m_dout
);

  localparam int unsigned CNT_WIDTH = OFS + 1;

  // Clears the word-offset bits of a memory address to get the line base.
  localparam logic [MEM_ADDR_WIDTH-1:0] LOW_MASK = MEM_ADDR_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT                      state;
  stateT                      nextState;

  // Read index; its top bit marks the final (write-only) cycle of a phase.
  logic [CNT_WIDTH-1:0]       cnt;
  logic [OFS-1:0]             rdIdx;
  // Write stream trails the read stream by one cycle.
  logic                       wrValid;
  logic [OFS-1:0]             wrIdx;
  logic                       lastCycle;

  logic [SET_WIDTH-1:0]       setR;
  logic [MEM_ADDR_WIDTH-1:0]  victimBase;
  logic [MEM_ADDR_WIDTH-1:0]  missBase;

  logic                       accept;

  assign rdIdx     = cnt[OFS-1:0];
  assign lastCycle = cnt[OFS];
  assign accept    = (state == IDLE) && req_valid;

  // Data moves straight across between the two RAM ports.
  assign c_din = m_dout;
  assign m_din = c_dout;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; each transfer phase lasts LINE_WORDS+1 cycles
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req_valid) nextState = req_wb ? WB : REFILL;
      WB:      if (lastCycle) nextState = REFILL;
      REFILL:  if (lastCycle) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture and word counters
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt        <= '0;
      wrValid    <= 1'b0;
      wrIdx      <= '0;
      setR       <= '0;
      victimBase <= '0;
      missBase   <= '0;
    end else begin
      if (accept) begin
        setR       <= req_set;
        victimBase <= req_victim_addr & ~LOW_MASK;
        missBase   <= req_miss_addr & ~LOW_MASK;
      end

      if (state == WB || state == REFILL) begin
        if (lastCycle) begin
          // Rearm for the next phase; the counter never wraps mid-line.
          cnt     <= '0;
          wrValid <= 1'b0;
        end else begin
          cnt     <= cnt + CNT_WIDTH'(1);
          wrValid <= 1'b1;
          wrIdx   <= rdIdx;
        end
      end else begin
        cnt     <= '0;
        wrValid <= 1'b0;
      end
    end
  end

  // Output decode from state and counter registers only
  always_comb begin
    c_en      = 1'b0;
    c_we      = '0;
    c_addr    = '0;
    m_en      = 1'b0;
    m_we      = '0;
    m_addr    = '0;
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);

    case (state)
      // Victim: read cache, write memory one cycle later.
      WB: begin
        if (!lastCycle) begin
          c_en   = 1'b1;
          c_addr = {setR, rdIdx};
        end
        if (wrValid) begin
          m_en   = 1'b1;
          m_we   = '1;
          // Base low bits are zero, so OR never carries into the line tag.
          m_addr = victimBase | MEM_ADDR_WIDTH'(wrIdx);
        end
      end
      // Refill: read memory, write cache one cycle later.
      REFILL: begin
        if (!lastCycle) begin
          m_en   = 1'b1;
          m_addr = missBase | MEM_ADDR_WIDTH'(rdIdx);
        end
        if (wrValid) begin
          c_en   = 1'b1;
          c_we   = '1;
          c_addr = {setR, wrIdx};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_line_mover.sv
// -----------------------------------------------------------------------------
// tb_dcache_line_mover
// Directed bench for dcache_line_mover with behavioural 1-cycle-latency
// byte-write RAM models on the cache and memory B ports.
// -----------------------------------------------------------------------------
module tb_dcache_line_mover;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = NC * CW;

  logic          clk;
  logic          nrst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wb;
  logic [5:0]    req_set;
  logic [10:0]   req_victim_addr;
  logic [10:0]   req_miss_addr;
  logic          busy;
  logic          done;
  logic          c_en;
  logic [NC-1:0] c_we;
  logic [7:0]    c_addr;
  logic [DW-1:0] c_din;
  logic [DW-1:0] c_dout;
  logic          m_en;
  logic [NC-1:0] m_we;
  logic [10:0]   m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  dcache_line_mover dut (
    .clk             (clk),
    .nrst            (nrst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wb          (req_wb),
    .req_set         (req_set),
    .req_victim_addr (req_victim_addr),
    .req_miss_addr   (req_miss_addr),
    .busy            (busy),
    .done            (done),
    .c_en            (c_en),
    .c_we            (c_we),
    .c_addr          (c_addr),
    .c_din           (c_din),
    .c_dout          (c_dout),
    .m_en            (m_en),
    .m_we            (m_we),
    .m_addr          (m_addr),
    .m_din           (m_din),
    .m_dout          (m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models with a backdoor loader so each array has a single writer.
  logic [DW-1:0] cmem [0:255];
  logic [DW-1:0] mem  [0:2047];
  logic [DW-1:0] cDoutR;
  logic [DW-1:0] mDoutR;
  logic          ldCEn;
  logic          ldMEn;
  logic [7:0]    ldCAddr;
  logic [10:0]   ldMAddr;
  logic [DW-1:0] ldData;

  assign c_dout = cDoutR;
  assign m_dout = mDoutR;

  always @(posedge clk) begin
    if (c_en) begin
      for (int b = 0; b < NC; b++)
        if (c_we[b]) cmem[c_addr][b*CW +: CW] <= c_din[b*CW +: CW];
      cDoutR <= cmem[c_addr];
    end
    if (ldCEn) cmem[ldCAddr] <= ldData;
    if (m_en) begin
      for (int b = 0; b < NC; b++)
        if (m_we[b]) mem[m_addr][b*CW +: CW] <= m_din[b*CW +: CW];
      mDoutR <= mem[m_addr];
    end
    if (ldMEn) mem[ldMAddr] <= ldData;
  end

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic loadC(input logic [7:0] a, input logic [DW-1:0] d);
    ldCAddr = a;
    ldData  = d;
    ldCEn   = 1'b1;
    @(negedge clk);
    ldCEn   = 1'b0;
  endtask

  task automatic loadM(input logic [10:0] a, input logic [DW-1:0] d);
    ldMAddr = a;
    ldData  = d;
    ldMEn   = 1'b1;
    @(negedge clk);
    ldMEn   = 1'b0;
  endtask

  // Per-cycle observation log, index = cycle number after acceptance.
  logic        busyLog  [0:31];
  logic        doneLog  [0:31];
  logic        readyLog [0:31];
  int          doneCount;
  int          firstDone;
  int          busyCount;
  int          mWrites;
  logic [7:0]  minC;
  logic [7:0]  maxC;
  logic [10:0] minM;
  logic [10:0] maxM;

  task automatic watch(input int nCyc, input int dropAt);
    doneCount = 0;
    firstDone = 0;
    busyCount = 0;
    mWrites   = 0;
    minC = '1; maxC = '0; minM = '1; maxM = '0;
    for (int n = 1; n <= nCyc; n++) begin
      @(negedge clk);
      busyLog[n]  = busy;
      doneLog[n]  = done;
      readyLog[n] = req_ready;
      if (busy) busyCount++;
      if (done) begin
        if (doneCount == 0) firstDone = n;
        doneCount++;
      end
      if (m_we != '0) mWrites++;
      if (c_en) begin
        if (c_addr < minC) minC = c_addr;
        if (c_addr > maxC) maxC = c_addr;
      end
      if (m_en) begin
        if (m_addr < minM) minM = m_addr;
        if (m_addr > maxM) maxM = m_addr;
      end
      if (n == dropAt) req_valid = 1'b0;
    end
  endtask

  // Presents a request at a falling edge; returns just after the accept edge.
  task automatic issue(input logic wb, input logic [5:0] set,
                       input logic [10:0] vic, input logic [10:0] miss);
    @(negedge clk);
    check("ready_before_accept", req_ready, 1);
    req_wb          = wb;
    req_set         = set;
    req_victim_addr = vic;
    req_miss_addr   = miss;
    req_valid       = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; req_valid = 1'b1; req_wb = 1'b1; req_set = 6'h15;
    req_victim_addr = 11'h3AB; req_miss_addr = 11'h155;
    ldCEn = 1'b0; ldMEn = 1'b0; ldCAddr = '0; ldMAddr = '0; ldData = '0;

    // Reset state while a request is held valid
    #2;
    check("rst_ready", req_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_en_we", {c_en, c_we, m_en, m_we}, 0);
    check("rst_addr",  {c_addr, m_addr}, 0);
    req_valid = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_busy",  busy, 0);
    check("idle_en_we", {done, c_en, c_we, m_en, m_we}, 0);

    // Dirty miss: set 5, victim base 0x100, miss base 0x228
    for (int k = 0; k < 4; k++) begin
      loadC(8'h14 + 8'(k), 32'hA0A0A000 + 32'(k));
      loadM(11'h228 + 11'(k), 32'hB0B0B000 + 32'(k));
      loadM(11'h100 + 11'(k), 32'h0);
    end
    issue(1'b1, 6'd5, 11'h103, 11'h22A);
    watch(13, 1);
    check("dirty_done_cycle", firstDone, 11);
    check("dirty_done_count", doneCount, 1);
    check("dirty_busy_count", busyCount, 11);
    check("dirty_busy_c1",    busyLog[1], 1);
    check("dirty_busy_c12",   busyLog[12], 0);
    check("dirty_ready_c5",   readyLog[5], 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dirty_mem_%0d", k),   mem[11'h100 + 11'(k)], 32'hA0A0A000 + 32'(k));
      check($sformatf("dirty_cache_%0d", k), cmem[8'h14 + 8'(k)],   32'hB0B0B000 + 32'(k));
    end

    // Clean miss on the same setup
    for (int k = 0; k < 4; k++) begin
      loadC(8'h14 + 8'(k), 32'hA0A0A000 + 32'(k));
      loadM(11'h100 + 11'(k), 32'hDEAD0000 + 32'(k));
    end
    issue(1'b0, 6'd5, 11'h103, 11'h22A);
    watch(8, 1);
    check("clean_done_cycle", firstDone, 6);
    check("clean_done_count", doneCount, 1);
    check("clean_busy_count", busyCount, 6);
    check("clean_busy_c7",    busyLog[7], 0);
    check("clean_mem_writes", mWrites, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("clean_cache_%0d", k), cmem[8'h14 + 8'(k)],   32'hB0B0B000 + 32'(k));
      check($sformatf("clean_mem_%0d", k),   mem[11'h100 + 11'(k)], 32'hDEAD0000 + 32'(k));
    end

    // Back-to-back with req_valid held: clean set 2 then dirty set 7
    for (int k = 0; k < 4; k++) begin
      loadM(11'h040 + 11'(k), 32'hC0C0C000 + 32'(k));
      loadC(8'h1C + 8'(k),    32'hD0D0D000 + 32'(k));
      loadM(11'h110 + 11'(k), 32'hE0E0E000 + 32'(k));
      loadM(11'h300 + 11'(k), 32'h0);
    end
    issue(1'b0, 6'd2, 11'h000, 11'h041);
    #1;
    req_wb = 1'b1; req_set = 6'd7; req_victim_addr = 11'h302; req_miss_addr = 11'h113;
    watch(20, 8);
    check("b2b_done_count",  doneCount, 2);
    check("b2b_first_done",  firstDone, 6);
    check("b2b_second_done", doneLog[18], 1);
    check("b2b_ready_c7",    readyLog[7], 1);
    check("b2b_busy_c7",     busyLog[7], 0);
    check("b2b_busy_c8",     busyLog[8], 1);
    check("b2b_busy_count",  busyCount, 17);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b_c1_%0d", k), cmem[8'h08 + 8'(k)],   32'hC0C0C000 + 32'(k));
      check($sformatf("b2b_wb_%0d", k), mem[11'h300 + 11'(k)], 32'hD0D0D000 + 32'(k));
      check($sformatf("b2b_c2_%0d", k), cmem[8'h1C + 8'(k)],   32'hE0E0E000 + 32'(k));
    end

    // Top set and top of memory: no wrap or carry
    for (int k = 0; k < 4; k++)
      loadM(11'h7FC + 11'(k), 32'hF0F0F000 + 32'(k));
    loadC(8'h00, 32'h5A5A5A5A);
    issue(1'b0, 6'h3F, 11'h000, 11'h7FD);
    watch(7, 1);
    check("edge_done_cycle", firstDone, 6);
    check("edge_min_c", minC, 8'hFC);
    check("edge_max_c", maxC, 8'hFF);
    check("edge_min_m", minM, 11'h7FC);
    check("edge_max_m", maxM, 11'h7FF);
    check("edge_cache0", cmem[8'h00], 32'h5A5A5A5A);
    for (int k = 0; k < 4; k++)
      check($sformatf("edge_cache_%0d", k), cmem[8'hFC + 8'(k)], 32'hF0F0F000 + 32'(k));

    // Reset during write-back
    issue(1'b1, 6'd5, 11'h103, 11'h22A);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midwb_c_en_c3", c_en, 1);
    check("midwb_m_en_c3", m_en, 1);
    nrst = 1'b0;
    #1;
    check("midwb_rst_en_we", {c_en, c_we, m_en, m_we}, 0);
    check("midwb_rst_ready", req_ready, 1);
    check("midwb_rst_busy",  {busy, done}, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    watch(5, 0);
    check("midwb_no_done", doneCount, 0);
    check("midwb_no_busy", busyCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
